// File: rtl/sdram_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port SDRAM command arbiter.
package sdram_arbiter_pkg;

  localparam int unsigned ARB_PORTS    = 2;
  localparam int unsigned SDRAM_ADDR_W = 22;
  localparam int unsigned SDRAM_DATA_W = 16;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ARB_WAIT_INIT = 2'd0,
    ARB_IDLE      = 2'd1,
    ARB_ISSUE     = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Port-id FIFO for outstanding reads; returned data is steered in issue order.
module sdram_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] count_n;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter with in-order read-return steering.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 1 wins).
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = SDRAM_ADDR_W,
  parameter int unsigned DATA_W          = SDRAM_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   init_done,
  input  logic [ARB_PORTS-1:0]   p_req,
  input  logic [ARB_PORTS-1:0]   p_we,
  input  logic [2*ADDR_W-1:0]    p_addr,
  input  logic [2*DATA_W-1:0]    p_wdata,
  input  logic [3:0]             p_be_n,
  output logic [ARB_PORTS-1:0]   p_ack,
  output logic [ARB_PORTS-1:0]   p_rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      az_addr,
  output logic [1:0]             az_be_n,
  output logic                   az_cs,
  output logic [DATA_W-1:0]      az_data,
  output logic                   az_rd_n,
  output logic                   az_wr_n,
  input  logic [DATA_W-1:0]      za_data,
  input  logic                   za_valid,
  input  logic                   za_waitrequest,
  output logic                   rd_underflow
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e               state, state_n;
  logic [ADDR_W-1:0]        az_addr_n;
  logic [1:0]               az_be_n_n;
  logic                     az_cs_n;
  logic [DATA_W-1:0]        az_data_n;
  logic                     az_rd_n_n;
  logic                     az_wr_n_n;
  logic [ARB_PORTS-1:0]     p_ack_n;
  logic [ARB_PORTS-1:0]     p_rvalid_n;
  logic [DATA_W-1:0]        rdata_n;
  logic                     rd_underflow_n;
  logic                     gnt, gnt_n;
  logic [ARB_PORTS-1:0]     elig;
  logic                     win;
  logic                     push;
  logic                     pop;
  logic                     fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic                     last_grant, last_grant_n;
`endif

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push),
    .din      (gnt),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Reads wait for a free tag slot; writes never need one.
  assign elig = p_req & (p_we | {ARB_PORTS{~fifo_full}});

  always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    win = (elig == 2'b11) ? ~last_grant : elig[PORT_DATA];
`else
    win = elig[PORT_DATA];
`endif
  end

  always_comb begin
    state_n        = state;
    az_addr_n      = az_addr;
    az_be_n_n      = az_be_n;
    az_cs_n        = az_cs;
    az_data_n      = az_data;
    az_rd_n_n      = az_rd_n;
    az_wr_n_n      = az_wr_n;
    p_ack_n        = '0;
    p_rvalid_n     = '0;
    rdata_n        = rdata;
    rd_underflow_n = rd_underflow;
    gnt_n          = gnt;
    push           = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_grant_n   = last_grant;
`endif

    case (state)
      ARB_WAIT_INIT: begin
        if (init_done) state_n = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (|elig) begin
          state_n   = ARB_ISSUE;
          gnt_n     = win;
          az_addr_n = win ? p_addr[2*ADDR_W-1:ADDR_W] : p_addr[ADDR_W-1:0];
          az_data_n = win ? p_wdata[2*DATA_W-1:DATA_W] : p_wdata[DATA_W-1:0];
          az_be_n_n = win ? p_be_n[3:2] : p_be_n[1:0];
          az_cs_n   = 1'b1;
          az_rd_n_n = p_we[win];
          az_wr_n_n = ~p_we[win];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          last_grant_n = win;
`endif
        end
      end
      ARB_ISSUE: begin
        if (!za_waitrequest) begin
          state_n      = ARB_IDLE;
          p_ack_n[gnt] = 1'b1;
          push         = ~az_rd_n;
          az_cs_n      = 1'b0;
          az_rd_n_n    = 1'b1;
          az_wr_n_n    = 1'b1;
        end
      end
      default: state_n = ARB_WAIT_INIT;
    endcase

    // Returned word goes to the oldest outstanding tag; orphans are dropped.
    if (pop) begin
      p_rvalid_n[fifo_dout] = 1'b1;
      rdata_n               = za_data;
    end
    if (za_valid && fifo_count == '0) rd_underflow_n = 1'b1;
  end

  assign pop = za_valid & ~fifo_empty;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= ARB_WAIT_INIT;
      az_addr      <= '0;
      az_be_n      <= '0;
      az_cs        <= 1'b0;
      az_data      <= '0;
      az_rd_n      <= 1'b1;
      az_wr_n      <= 1'b1;
      p_ack        <= '0;
      p_rvalid     <= '0;
      rdata        <= '0;
      rd_underflow <= 1'b0;
      gnt          <= PORT_FETCH;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant   <= PORT_DATA;
`endif
    end else begin
      state        <= state_n;
      az_addr      <= az_addr_n;
      az_be_n      <= az_be_n_n;
      az_cs        <= az_cs_n;
      az_data      <= az_data_n;
      az_rd_n      <= az_rd_n_n;
      az_wr_n      <= az_wr_n_n;
      p_ack        <= p_ack_n;
      p_rvalid     <= p_rvalid_n;
      rdata        <= rdata_n;
      rd_underflow <= rd_underflow_n;
      gnt          <= gnt_n;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant   <= last_grant_n;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (both arbitration builds).
module tb_sdram_arbiter;

  logic        CLOCK_50;
  logic        reset;
  logic        init_done;
  logic [1:0]  p_req;
  logic [1:0]  p_we;
  logic [43:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be_n;
  logic [1:0]  p_ack;
  logic [1:0]  p_rvalid;
  logic [15:0] rdata;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic        az_cs;
  logic [15:0] az_data;
  logic        az_rd_n;
  logic        az_wr_n;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;
  logic        rd_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_arbiter dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .init_done      (init_done),
    .p_req          (p_req),
    .p_we           (p_we),
    .p_addr         (p_addr),
    .p_wdata        (p_wdata),
    .p_be_n         (p_be_n),
    .p_ack          (p_ack),
    .p_rvalid       (p_rvalid),
    .rdata          (rdata),
    .az_addr        (az_addr),
    .az_be_n        (az_be_n),
    .az_cs          (az_cs),
    .az_data        (az_data),
    .az_rd_n        (az_rd_n),
    .az_wr_n        (az_wr_n),
    .za_data        (za_data),
    .za_valid       (za_valid),
    .za_waitrequest (za_waitrequest),
    .rd_underflow   (rd_underflow)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic we, input logic [21:0] addr,
                         input logic [15:0] data);
    p_we[port]             = we;
    p_addr[port*22 +: 22]  = addr;
    p_wdata[port*16 +: 16] = data;
    p_be_n[port*2 +: 2]    = 2'b00;
    p_req[port]            = 1'b1;
  endtask

  // Bounded wait for any ack pulse; returns 0 on timeout.
  task automatic wait_any_ack(output logic [1:0] ack);
    ack = 2'b00;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (p_ack != 2'b00) begin
        ack = p_ack;
        break;
      end
    end
  endtask

  task automatic do_cmd(input int port, input logic we, input logic [21:0] addr,
                        input logic [15:0] data, input string tag);
    logic [1:0] ack;
    set_req(port, we, addr, data);
    wait_any_ack(ack);
    check(tag, 32'(ack), (port == 1) ? 32'h2 : 32'h1);
    p_req[port] = 1'b0;
  endtask

  initial begin
    logic [1:0] ack;
    int         activity;
    int         seen;

    reset = 1'b1; init_done = 1'b0;
    p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0; p_be_n = '1;
    za_data = '0; za_valid = 1'b0; za_waitrequest = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_rd_n", 32'(az_rd_n), 32'h1);
    check("rst_wr_n", 32'(az_wr_n), 32'h1);
    check("rst_cs", 32'(az_cs), 32'h0);
    check("rst_addr", 32'(az_addr), 32'h0);
    check("rst_ack_rvalid", 32'({p_ack, p_rvalid}), 32'h0);
    check("rst_rdata_uf", 32'({rdata, rd_underflow}), 32'h0);

    // No command while the controller is still initialising.
    reset = 1'b0;
    set_req(0, 1'b0, 22'h000005, 16'h0000);
    activity = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!az_rd_n || !az_wr_n || az_cs) activity++;
    end
    check("init_quiet", 32'(activity), 32'h0);
    init_done = 1'b1;
    tick();
    check("init_idle_cs", 32'(az_cs), 32'h0);
    tick();
    check("init_rd_cmd", 32'({az_cs, az_rd_n, az_wr_n}), 32'h5);
    check("init_rd_addr", 32'(az_addr), 32'h5);
    tick();
    check("init_rd_ack", 32'(p_ack), 32'h1);
    check("init_cmd_drop", 32'({az_cs, az_rd_n, az_wr_n}), 32'h3);
    p_req[0] = 1'b0;
    za_valid = 1'b1; za_data = 16'h0BAD;
    tick();
    za_valid = 1'b0;
    check("init_rvalid", 32'(p_rvalid), 32'h1);
    check("init_rdata", 32'(rdata), 32'h0BAD);

    // Write held stable across three waitrequest cycles.
    za_waitrequest = 1'b1;
    set_req(0, 1'b1, 22'h000010, 16'hA5C3);
    tick();
    check("wr_cmd", 32'({az_cs, az_rd_n, az_wr_n}), 32'h6);
    check("wr_addr", 32'(az_addr), 32'h10);
    check("wr_data", 32'(az_data), 32'hA5C3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_stall_stable", 32'({az_cs, az_rd_n, az_wr_n, az_addr, az_data[4:0]}),
            32'({3'b110, 22'h000010, 5'h03}));
      check("wr_stall_noack", 32'(p_ack), 32'h0);
    end
    za_waitrequest = 1'b0;
    tick();
    check("wr_ack", 32'(p_ack), 32'h1);
    check("wr_release", 32'({az_cs, az_wr_n}), 32'h1);
    p_req[0] = 1'b0;

    // Two reads, returned in issue order to their own ports.
    set_req(1, 1'b0, 22'h000020, 16'h0000);
    set_req(0, 1'b0, 22'h000021, 16'h0000);
    tick();
    check("rd1_addr", 32'(az_addr), 32'h20);
    tick();
    check("rd1_ack", 32'(p_ack), 32'h2);
    p_req[1] = 1'b0;
    tick();
    check("rd0_addr", 32'(az_addr), 32'h21);
    tick();
    check("rd0_ack", 32'(p_ack), 32'h1);
    p_req[0] = 1'b0;
    za_valid = 1'b1; za_data = 16'h1111;
    tick();
    check("ret1_rvalid", 32'(p_rvalid), 32'h2);
    check("ret1_rdata", 32'(rdata), 32'h1111);
    za_data = 16'h2222;
    tick();
    za_valid = 1'b0;
    check("ret2_rvalid", 32'(p_rvalid), 32'h1);
    check("ret2_rdata", 32'(rdata), 32'h2222);

    // Fresh reset so the arbitration history is known, then contend.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 22'h000100, 16'h0000);
    set_req(1, 1'b1, 22'h000200, 16'h1111);
    for (int i = 0; i < 8; i++) begin
      wait_any_ack(ack);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      check("contend_grant", 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
      check("contend_grant", 32'(ack), 32'h2);
`endif
    end
    p_req = 2'b00;
    p_we  = 2'b00;

    // Fill the tag FIFO; a further read blocks while a write gets through.
    for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 22'(32'h30 + i), 16'h0000, "fill_ack");
    set_req(0, 1'b0, 22'h000034, 16'h0000);
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (az_cs) activity++;
    end
    check("full_rd_blocked", 32'(activity), 32'h0);
    set_req(1, 1'b1, 22'h000040, 16'hBEEF);
    wait_any_ack(ack);
    check("full_wr_ack", 32'(ack), 32'h2);
    p_req[1] = 1'b0;
    za_valid = 1'b1; za_data = 16'h3333;
    tick();
    za_valid = 1'b0;
    check("full_pop_rvalid", 32'(p_rvalid), 32'h1);
    check("full_pop_rdata", 32'(rdata), 32'h3333);
    wait_any_ack(ack);
    check("fifth_rd_ack", 32'(ack), 32'h1);
    p_req[0] = 1'b0;
    seen = 0;
    za_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      za_data = 16'(16'h4000 + i);
      tick();
      if (p_rvalid == 2'b01 && rdata == 16'(16'h4000 + i)) seen++;
    end
    za_valid = 1'b0;
    check("drain_rvalid", 32'(seen), 32'h4);
    check("drain_no_uf", 32'(rd_underflow), 32'h0);

    // Orphan read data.
    za_valid = 1'b1; za_data = 16'h5555;
    tick();
    za_valid = 1'b0;
    check("uf_set", 32'(rd_underflow), 32'h1);
    check("uf_no_rvalid", 32'(p_rvalid), 32'h0);
    tick();
    check("uf_sticky", 32'(rd_underflow), 32'h1);

    // Reset in the middle of a stalled read.
    za_waitrequest = 1'b1;
    set_req(0, 1'b0, 22'h000050, 16'h0000);
    tick();
    check("mid_issue_cs", 32'(az_cs), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_cmd", 32'({az_cs, az_rd_n, az_wr_n}), 32'h3);
    check("mid_rst_addr", 32'(az_addr), 32'h0);
    check("mid_rst_uf", 32'(rd_underflow), 32'h0);
    check("mid_rst_pulses", 32'({p_ack, p_rvalid}), 32'h0);
    p_req = 2'b00;
    za_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    activity = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p_ack != 2'b00 || p_rvalid != 2'b00) activity++;
    end
    check("post_rst_quiet", 32'(activity), 32'h0);
    za_valid = 1'b1; za_data = 16'h6666;
    tick();
    za_valid = 1'b0;
    check("post_rst_tags_gone", 32'({rd_underflow, p_rvalid}), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
